// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction fields in, forwarding selects and stall status out.
// Purely a signal bundle: no logic, no latency, no flow control of its own.
// The controller drives stall back to the front end as its only backpressure.
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic             stall;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rt, id_rd, id_regwrite, id_memread, flush,
        input  stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rt, id_rd, id_regwrite, id_memread, flush,
        output stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generator and load-use hazard detector for a 5-stage pipe.
// Latency: stall is combinational from ID fields; ex_fwd_a/b are registered into EX.
// Backpressure: asserts stall for one cycle per load-use hazard; flush overrides stall.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_ctrl_if.slave  bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } rec_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_RET = 2'b11;

    // The RET stage needs no record of its own: its write data is selected
    // through the WB record one cycle before that instruction reaches RET.
    rec_t ex_q;
    rec_t mem_q;
    rec_t wb_q;

    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_b_q;
    logic [CNT_W-1:0] cnt_q;

    logic       load_hit;
    logic       stall_c;
    logic       bubble;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    function automatic logic is_producer(input rec_t r);
        return r.valid && r.regwrite && (r.rd != '0);
    endfunction

    // Youngest matching producer wins; its pipeline distance is the select code.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input rec_t             ex_r,
        input rec_t             mem_r,
        input rec_t             wb_r
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (is_producer(ex_r) && (ex_r.rd == src)) begin
            sel = SEL_MEM;
        end else if (is_producer(mem_r) && (mem_r.rd == src)) begin
            sel = SEL_WB;
        end else if (is_producer(wb_r) && (wb_r.rd == src)) begin
            sel = SEL_RET;
        end
        return sel;
    endfunction

    always_comb begin
        load_hit = 1'b0;
        stall_c  = 1'b0;
        bubble   = 1'b0;
        sel_a    = SEL_RF;
        sel_b    = SEL_RF;

        load_hit = is_producer(ex_q) && ex_q.memread &&
                   ((ex_q.rd == bus.id_rs) || (bus.id_use_rt && (ex_q.rd == bus.id_rt)));
        stall_c  = bus.id_valid && !bus.flush && load_hit;
        bubble   = stall_c || bus.flush || !bus.id_valid;

        sel_a = fwd_sel(bus.id_rs, ex_q, mem_q, wb_q);
        if (bus.id_use_rt) begin
            sel_b = fwd_sel(bus.id_rt, ex_q, mem_q, wb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (bubble) begin
                ex_q    <= '0;
                fwd_a_q <= SEL_RF;
                fwd_b_q <= SEL_RF;
            end else begin
                ex_q.valid    <= 1'b1;
                ex_q.rd       <= bus.id_rd;
                ex_q.regwrite <= bus.id_regwrite;
                ex_q.memread  <= bus.id_memread;
                fwd_a_q       <= sel_a;
                fwd_b_q       <= sel_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_c && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.ex_fwd_a  = fwd_a_q;
    assign bus.ex_fwd_b  = fwd_b_q;
    assign bus.stall_cnt = cnt_q;

endmodule
